// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, padding constants and the second-block builder.
// Build macro SHA256_FEEDER_NONCE_BSWAP_EN places the nonce byte-swapped in block2.
package sha256_pkg;

    typedef logic [0:255] midstate_t;
    typedef logic [0:511] block_t;
    typedef logic [0:95]  tail_t;
    typedef logic [31:0]  nonce_t;

    localparam logic SHA_PAD_ONE  = 1'b1;
    localparam int   HDR_LEN_BITS = 640;

    // Bit 0 is the first message bit: tail, nonce, pad one, zeros, 64-bit length.
    function automatic block_t build_block2(
        input tail_t       tail,
        input nonce_t      nonce,
        input logic [63:0] len_bits = 64'(HDR_LEN_BITS)
    );
        block_t blk;
        blk = '0;
        blk[0:95] = tail;
`ifdef SHA256_FEEDER_NONCE_BSWAP_EN
        blk[96:127] = {nonce[7:0], nonce[15:8], nonce[23:16], nonce[31:24]};
`else
        blk[96:127] = nonce;
`endif
        blk[128] = SHA_PAD_ONE;
        blk[448:511] = len_bits;
        return blk;
    endfunction

endpackage

// File: rtl/sha256_nonce_range_ctr.sv
// Nonce range counter: loads start/end, steps by one modulo 2^NONCE_W,
// and flags the inclusive last nonce (wraps through all-ones naturally).
module sha256_nonce_range_ctr #(
    parameter int NONCE_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [NONCE_W-1:0] nonce_start,
    input  logic [NONCE_W-1:0] nonce_end,
    input  logic               advance,
    output logic [NONCE_W-1:0] nonce,
    output logic               last
);

    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [NONCE_W-1:0] end_q, end_d;

    always_comb begin
        nonce_d = nonce_q;
        end_d   = end_q;
        if (load) begin
            nonce_d = nonce_start;
            end_d   = nonce_end;
        end else if (advance) begin
            nonce_d = nonce_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nonce_q <= '0;
            end_q   <= '0;
        end else begin
            nonce_q <= nonce_d;
            end_q   <= end_d;
        end
    end

    assign nonce = nonce_q;
    assign last  = (nonce_q == end_q);

endmodule

// File: rtl/sha256_work_feeder.sv
// Issues one padded second block per nonce of a job to the hasher.
// Optional macro SHA256_FEEDER_NONCE_BSWAP_EN byte-swaps the nonce inside block2.
module sha256_work_feeder
    import sha256_pkg::*;
#(
    parameter int LEN_BITS = 640,
    parameter int NONCE_W  = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [0:255] job_midstate,
    input  logic [0:95]  job_tail,
    input  logic [31:0]  job_nonce_start,
    input  logic [31:0]  job_nonce_end,
    input  logic         job_abort,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:255] out_midstate,
    output logic [0:511] out_block2,
    output logic [31:0]  out_nonce,
    output logic         done,
    output logic [32:0]  issued_cnt
);

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t      state_q, state_d;
    midstate_t   midstate_q, midstate_d;
    tail_t       tail_q, tail_d;
    logic        blk_en_q, blk_en_d;
    logic        done_q, done_d;
    logic [32:0] issued_cnt_q, issued_cnt_d;

    logic   ctr_load, ctr_advance, ctr_last;
    nonce_t ctr_nonce;

    // Handshake: an item transfers on a clock edge where out_valid & out_ready;
    // once raised, out_valid and the item stay put until that edge (or an abort).
    logic hs;
    assign hs = (state_q == ISSUE) && out_ready;

    always_comb begin
        state_d      = state_q;
        midstate_d   = midstate_q;
        tail_d       = tail_q;
        blk_en_d     = blk_en_q;
        done_d       = 1'b0;
        issued_cnt_d = issued_cnt_q;
        ctr_load     = 1'b0;
        ctr_advance  = 1'b0;
        case (state_q)
            IDLE: begin
                if (job_valid) begin
                    midstate_d   = job_midstate;
                    tail_d       = job_tail;
                    blk_en_d     = 1'b1;
                    issued_cnt_d = '0;
                    ctr_load     = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (hs) begin
                    issued_cnt_d = issued_cnt_q + 33'd1;
                end
                // Abort wins over continuing, but a coincident handshake still counts.
                if (job_abort || (hs && ctr_last)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (hs) begin
                    ctr_advance = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            midstate_q   <= '0;
            tail_q       <= '0;
            blk_en_q     <= 1'b0;
            done_q       <= 1'b0;
            issued_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            midstate_q   <= midstate_d;
            tail_q       <= tail_d;
            blk_en_q     <= blk_en_d;
            done_q       <= done_d;
            issued_cnt_q <= issued_cnt_d;
        end
    end

    sha256_nonce_range_ctr #(
        .NONCE_W(NONCE_W)
    ) u_ctr (
        .clk         (clk),
        .rst         (rst),
        .load        (ctr_load),
        .nonce_start (job_nonce_start),
        .nonce_end   (job_nonce_end),
        .advance     (ctr_advance),
        .nonce       (ctr_nonce),
        .last        (ctr_last)
    );

    assign job_ready    = (state_q == IDLE);
    assign out_valid    = (state_q == ISSUE);
    assign out_midstate = midstate_q;
    assign out_nonce    = ctr_nonce;
    // Block stays all-zero until the first job so reset values are clean.
    assign out_block2   = blk_en_q ? build_block2(tail_q, ctr_nonce, 64'(LEN_BITS)) : '0;
    assign done         = done_q;
    assign issued_cnt   = issued_cnt_q;

endmodule

// File: tb/tb_sha256_work_feeder.sv
// Self-checking bench for sha256_work_feeder: scoreboard of expected items
// plus per-scenario tasks with inline checks.
module tb_sha256_work_feeder;

    logic         clk = 1'b0;
    logic         rst;
    logic         job_valid;
    logic         job_ready;
    logic [0:255] job_midstate;
    logic [0:95]  job_tail;
    logic [31:0]  job_nonce_start;
    logic [31:0]  job_nonce_end;
    logic         job_abort;
    logic         out_valid;
    logic         out_ready;
    logic [0:255] out_midstate;
    logic [0:511] out_block2;
    logic [31:0]  out_nonce;
    logic         done;
    logic [32:0]  issued_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0]  exp_nonce_q[$];
    logic [511:0] exp_block_q[$];
    logic [255:0] exp_mid_q[$];

    sha256_work_feeder dut (
        .clk             (clk),
        .rst             (rst),
        .job_valid       (job_valid),
        .job_ready       (job_ready),
        .job_midstate    (job_midstate),
        .job_tail        (job_tail),
        .job_nonce_start (job_nonce_start),
        .job_nonce_end   (job_nonce_end),
        .job_abort       (job_abort),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_midstate    (out_midstate),
        .out_block2      (out_block2),
        .out_nonce       (out_nonce),
        .done            (done),
        .issued_cnt      (issued_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] exp_block(input logic [95:0] t, input logic [31:0] n);
        logic [31:0] nf;
`ifdef SHA256_FEEDER_NONCE_BSWAP_EN
        nf = {n[7:0], n[15:8], n[23:16], n[31:24]};
`else
        nf = n;
`endif
        return {t, nf, 1'b1, 319'b0, 64'd640};
    endfunction

    // Scoreboard: compare every transferred item against the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_nonce_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: unexpected item nonce=%h, no item was expected", out_nonce);
            end else begin
                logic [31:0]  en;
                logic [511:0] eb;
                logic [255:0] em;
                en = exp_nonce_q.pop_front();
                eb = exp_block_q.pop_front();
                em = exp_mid_q.pop_front();
                if (out_nonce !== en) begin
                    errors++;
                    $display("FAIL sb_nonce: got %h want %h", out_nonce, en);
                end
                checks++;
                if (out_block2 !== eb) begin
                    errors++;
                    $display("FAIL sb_block2 (nonce %h): got %h want %h", en, out_block2, eb);
                end
                checks++;
                if (out_midstate !== em) begin
                    errors++;
                    $display("FAIL sb_midstate (nonce %h): got %h want %h", en, out_midstate, em);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_sb();
        exp_nonce_q.delete();
        exp_block_q.delete();
        exp_mid_q.delete();
    endtask

    // Offers one job for a single cycle (caller ensures job_ready) and queues its items.
    task automatic start_job(input logic [255:0] m, input logic [95:0] t,
                             input logic [31:0] s, input logic [31:0] e);
        logic [31:0] n;
        n = s;
        forever begin
            exp_nonce_q.push_back(n);
            exp_block_q.push_back(exp_block(t, n));
            exp_mid_q.push_back(m);
            if (n == e) break;
            n = n + 32'd1;
        end
        job_midstate    = m;
        job_tail        = t;
        job_nonce_start = s;
        job_nonce_end   = e;
        job_valid       = 1'b1;
        step();
        job_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_nonce !== s) begin
            errors++;
            $display("FAIL job_accept: out_valid=%b nonce=%h want 1 / %h", out_valid, out_nonce, s);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (job_ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0 || issued_cnt !== 33'd0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b valid=%b done=%b cnt=%0d want 1 0 0 0",
                     job_ready, out_valid, done, issued_cnt);
        end
        checks++;
        if (out_midstate !== 256'd0 || out_block2 !== 512'd0 || out_nonce !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: nonce=%h block2 nonzero=%b midstate nonzero=%b want all zero",
                     out_nonce, |out_block2, |out_midstate);
        end
    endtask

    task automatic test_basic_range();
        logic [255:0] m;
        m = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b1;
        start_job(m, 96'h0102030405060708090a0b0c, 32'h10, 32'h13);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (done !== 1'b0 || out_valid !== 1'b1 || issued_cnt !== 33'(i + 1)) begin
                errors++;
                $display("FAIL basic_mid%0d: done=%b valid=%b cnt=%0d want 0 1 %0d",
                         i, done, out_valid, issued_cnt, i + 1);
            end
        end
        step();
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || issued_cnt !== 33'd4 || job_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_done: done=%b valid=%b cnt=%0d ready=%b want 1 0 4 1",
                     done, out_valid, issued_cnt, job_ready);
        end
        step();
        checks++;
        if (done !== 1'b0 || issued_cnt !== 33'd4) begin
            errors++;
            $display("FAIL basic_hold: done=%b cnt=%0d want 0 4", done, issued_cnt);
        end
    endtask

    task automatic test_padding();
        logic [511:0] lit;
        lit = {96'h626361626361626361626361, 32'h0, 8'h80, 312'h0, 64'h280};
        out_ready = 1'b0;
        start_job(256'h0, 96'h626361626361626361626361, 32'h0, 32'h0);
        checks++;
        if (out_block2 !== lit) begin
            errors++;
            $display("FAIL pad_layout: got %h want %h", out_block2, lit);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (done !== 1'b1 || issued_cnt !== 33'd1) begin
            errors++;
            $display("FAIL pad_single: done=%b cnt=%0d want 1 1", done, issued_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [31:0]  pn;
        logic [511:0] pb;
        logic         seen_done;
        seen_done = 1'b0;
        start_job(256'hdeadbeef, 96'hcafef00d0011223344556677, 32'hFFFFFFFE, 32'h00000001);
        for (int i = 0; i < 30 && !seen_done; i++) begin
            out_ready = (i % 2 == 1);
            pn = out_nonce;
            pb = out_block2;
            step();
            if (!out_ready && out_valid) begin
                checks++;
                if (out_nonce !== pn || out_block2 !== pb) begin
                    errors++;
                    $display("FAIL wrap_stable: nonce=%h want %h (block2 changed=%b)",
                             out_nonce, pn, out_block2 !== pb);
                end
            end
            seen_done = done;
        end
        out_ready = 1'b0;
        checks++;
        if (!seen_done || issued_cnt !== 33'd4 || exp_nonce_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_end: done_seen=%b cnt=%0d left=%0d want 1 4 0",
                     seen_done, issued_cnt, exp_nonce_q.size());
        end
    endtask

    task automatic test_abort();
        out_ready = 1'b1;
        start_job(256'h1234, 96'habc, 32'd0, 32'd99);
        step();
        job_abort = 1'b1;
        step();
        job_abort = 1'b0;
        out_ready = 1'b0;
        flush_sb();
        checks++;
        if (issued_cnt !== 33'd2 || out_valid !== 1'b0 || done !== 1'b1 || job_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort: cnt=%0d valid=%b done=%b ready=%b want 2 0 1 1",
                     issued_cnt, out_valid, done, job_ready);
        end
        job_abort = 1'b1;
        step();
        step();
        job_abort = 1'b0;
        checks++;
        if (done !== 1'b0 || job_ready !== 1'b1 || out_valid !== 1'b0 || issued_cnt !== 33'd2) begin
            errors++;
            $display("FAIL abort_idle: done=%b ready=%b valid=%b cnt=%0d want 0 1 0 2",
                     done, job_ready, out_valid, issued_cnt);
        end
    endtask

    task automatic test_reset_mid_job();
        out_ready = 1'b0;
        start_job(256'hfeed, 96'hbeef, 32'd0, 32'd9);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        flush_sb();
        checks++;
        if (job_ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0 || issued_cnt !== 33'd0 ||
            out_nonce !== 32'd0 || out_block2 !== 512'd0 || out_midstate !== 256'd0) begin
            errors++;
            $display("FAIL rst_mid: ready=%b valid=%b done=%b cnt=%0d nonce=%h want reset values",
                     job_ready, out_valid, done, issued_cnt, out_nonce);
        end
        start_job(256'h77, 96'h88, 32'd5, 32'd5);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (done !== 1'b1 || issued_cnt !== 33'd1) begin
            errors++;
            $display("FAIL rst_newjob: done=%b cnt=%0d want 1 1", done, issued_cnt);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        start_job(256'h20, 96'h21, 32'd20, 32'd20);
        step();
        checks++;
        if (done !== 1'b1 || job_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: done=%b ready=%b want 1 1", done, job_ready);
        end
        start_job(256'h30, 96'h31, 32'd30, 32'd31);
        checks++;
        if (done !== 1'b0 || issued_cnt !== 33'd0) begin
            errors++;
            $display("FAIL b2b_restart: done=%b cnt=%0d want 0 0", done, issued_cnt);
        end
        step();
        step();
        out_ready = 1'b0;
        checks++;
        if (done !== 1'b1 || issued_cnt !== 33'd2) begin
            errors++;
            $display("FAIL b2b_second: done=%b cnt=%0d want 1 2", done, issued_cnt);
        end
    endtask

    task automatic test_nonce_field();
        logic [0:511] blk;
        logic [31:0]  want;
`ifdef SHA256_FEEDER_NONCE_BSWAP_EN
        want = 32'h78563412;
`else
        want = 32'h12345678;
`endif
        out_ready = 1'b0;
        start_job(256'h5, 96'h6, 32'h12345678, 32'h12345678);
        blk = out_block2;
        checks++;
        if (blk[96:127] !== want || out_nonce !== 32'h12345678) begin
            errors++;
            $display("FAIL nonce_field: field=%h nonce=%h want %h / 12345678",
                     blk[96:127], out_nonce, want);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
    endtask

    task automatic test_random_ranges();
        logic [31:0] s;
        logic [31:0] len;
        logic        seen_done;
        for (int j = 0; j < 4; j++) begin
            s   = $urandom;
            len = 32'($urandom_range(1, 6));
            start_job({8{$urandom}}, {3{$urandom}}, s, s + len - 32'd1);
            seen_done = 1'b0;
            for (int i = 0; i < 40 && !seen_done; i++) begin
                out_ready = ($urandom_range(0, 1) == 1);
                step();
                seen_done = done;
            end
            out_ready = 1'b0;
            checks++;
            if (!seen_done || issued_cnt !== {1'b0, len}) begin
                errors++;
                $display("FAIL rand_range%0d: done_seen=%b cnt=%0d want 1 %0d",
                         j, seen_done, issued_cnt, len);
            end
        end
    endtask

    initial begin
        rst             = 1'b1;
        job_valid       = 1'b0;
        job_midstate    = '0;
        job_tail        = '0;
        job_nonce_start = '0;
        job_nonce_end   = '0;
        job_abort       = 1'b0;
        out_ready       = 1'b0;

        test_reset();
        test_basic_range();
        test_padding();
        test_wrap();
        test_abort();
        test_reset_mid_job();
        test_back_to_back();
        test_nonce_field();
        test_random_ranges();

        checks++;
        if (exp_nonce_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d items never issued, want 0", exp_nonce_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
